// File: rtl/stream_demux4.sv
// stream_demux4: one-to-four stream demultiplexer with a registered output slot per channel.
//
// Each upstream word carries a channel index (in_sel). It is accepted whenever the selected
// channel's slot is empty or is being drained in the same cycle, so a stalled channel never
// blocks traffic addressed to the others. Outputs come straight from the slot registers.
//
// Optional feature: define STREAM_DEMUX4_COUNT_EN to get an 8-bit wrapping output-transfer
// counter per channel on out_count. Without the macro, out_count is tied to 0 and no counter
// flops exist.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   upstream word present
//   in_ready   upstream word accepted this cycle
//   in_data    upstream payload, WIDTH bits
//   in_sel     destination channel, 0..3
//   out_valid  bit k: channel k holds a word
//   out_ready  bit k: channel k consumer takes the word
//   out_data   channel k payload in [k*WIDTH +: WIDTH]
//   out_count  channel k transfer count in [k*8 +: 8]
module stream_demux4 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_sel,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [31:0]        out_count
);

    logic [3:0]       valid_q, valid_d;
    logic [WIDTH-1:0] data_q [4];
    logic [WIDTH-1:0] data_d [4];
    logic [3:0]       out_fire;
    logic             in_fire;

    // Ready depends only on the addressed channel: free, or emptying this cycle.
    assign in_ready = !valid_q[in_sel] || out_ready[in_sel];
    assign in_fire  = in_valid && in_ready;
    assign out_fire = valid_q & out_ready;

    always_comb begin
        valid_d = valid_q;
        for (int k = 0; k < 4; k++) begin
            data_d[k] = data_q[k];
            if (in_fire && (in_sel == 2'(k))) begin
                // Load wins over drain, so a full slot refills without a bubble.
                valid_d[k] = 1'b1;
                data_d[k]  = in_data;
            end else if (out_fire[k]) begin
                valid_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign out_valid = valid_q;

    always_comb begin
        out_data = '0;
        for (int k = 0; k < 4; k++) begin
            out_data[k*WIDTH +: WIDTH] = data_q[k];
        end
    end

`ifdef STREAM_DEMUX4_COUNT_EN
    logic [7:0] count_q [4];
    logic [7:0] count_d [4];

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            count_d[k] = out_fire[k] ? count_q[k] + 8'd1 : count_q[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                count_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                count_q[k] <= count_d[k];
            end
        end
    end

    always_comb begin
        out_count = '0;
        for (int k = 0; k < 4; k++) begin
            out_count[k*8 +: 8] = count_q[k];
        end
    end
`else
    assign out_count = '0;
`endif

endmodule

// File: tb/tb_stream_demux4.sv
// Directed bench for stream_demux4 (WIDTH = 8). Inputs change 1 ns after the rising edge;
// registered outputs are sampled there and in_ready 1 ns later, well before the next edge.
// Counter expectations follow STREAM_DEMUX4_COUNT_EN (zero when it is undefined).
module tb_stream_demux4;

    localparam int unsigned WIDTH = 8;
`ifdef STREAM_DEMUX4_COUNT_EN
    localparam bit CountEn = 1'b1;
`else
    localparam bit CountEn = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [1:0]         in_sel;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic [4*WIDTH-1:0] out_data;
    logic [31:0]        out_count;

    int n_checks = 0;
    int n_errors = 0;

    stream_demux4 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] cnt(input logic [31:0] v);
        return CountEn ? v : 32'h0;
    endfunction

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        out_ready = '0;
        step();
        step();
        check_eq("reset out_valid", 32'(out_valid), 32'h0);
        check_eq("reset out_data", out_data, 32'h0);
        check_eq("reset out_count", out_count, 32'h0);
        rst = 1'b0;
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1;
            check_eq($sformatf("idle in_ready sel%0d", s), 32'(in_ready), 32'h1);
        end

        // Basic capture on channel 2, then stall
        in_sel   = 2'd2;
        in_data  = 8'hA5;
        in_valid = 1'b1;
        #1;
        check_eq("basic in_ready", 32'(in_ready), 32'h1);
        step();
        in_valid = 1'b0;
        in_data  = 8'hFF;
        #1;
        check_eq("basic out_valid", 32'(out_valid), 32'h4);
        check_eq("basic data2", 32'(out_data[23:16]), 32'hA5);
        check_eq("full in_ready sel2", 32'(in_ready), 32'h0);
        in_valid = 1'b1;  // refused: slot full and not drained
        step();
        in_valid = 1'b0;
        check_eq("hold data2", 32'(out_data[23:16]), 32'hA5);
        check_eq("hold out_valid", 32'(out_valid), 32'h4);
        out_ready = 4'b0100;
        step();
        out_ready = 4'b0000;
        check_eq("drain out_valid", 32'(out_valid), 32'h0);

        // Back-to-back streaming on channel 1
        in_sel    = 2'd1;
        out_ready = 4'b0010;
        for (int i = 1; i <= 10; i++) begin
            in_data  = 8'(i);
            in_valid = 1'b1;
            #1;
            check_eq($sformatf("stream in_ready %0d", i), 32'(in_ready), 32'h1);
            step();
            check_eq($sformatf("stream valid %0d", i), 32'(out_valid), 32'h2);
            check_eq($sformatf("stream data %0d", i), 32'(out_data[15:8]), 32'(i));
        end
        in_valid = 1'b0;
        step();
        check_eq("stream empty", 32'(out_valid), 32'h0);
        out_ready = 4'b0000;

        // Isolation: channel 0 stalled, channel 3 still accepts
        in_sel   = 2'd0;
        in_data  = 8'h5C;
        in_valid = 1'b1;
        step();
        in_sel  = 2'd3;
        in_data = 8'h33;
        #1;
        check_eq("iso in_ready sel3", 32'(in_ready), 32'h1);
        step();
        in_valid = 1'b0;
        check_eq("iso out_valid", 32'(out_valid), 32'h9);
        check_eq("iso data0", 32'(out_data[7:0]), 32'h5C);
        check_eq("iso data3", 32'(out_data[31:24]), 32'h33);

        // Simultaneous drain/refill on channel 2
        in_sel   = 2'd2;
        in_data  = 8'h11;
        in_valid = 1'b1;
        step();
        check_eq("dr hold 0x11", 32'(out_data[23:16]), 32'h11);
        out_ready = 4'b0100;
        in_data   = 8'h22;
        #1;
        check_eq("dr in_ready", 32'(in_ready), 32'h1);
        step();
        in_valid = 1'b0;
        check_eq("dr out_valid", 32'(out_valid), 32'hD);
        check_eq("dr data2", 32'(out_data[23:16]), 32'h22);
        step();
        out_ready = 4'b0000;
        check_eq("dr drained", 32'(out_valid), 32'h9);
        // ch1: 10 words, ch2: A5, 11, 22
        check_eq("counts mid", out_count, cnt(32'h00030A00));

        // Drain all, fill all, then reset while draining
        out_ready = 4'hF;
        step();
        out_ready = 4'h0;
        check_eq("all drained", 32'(out_valid), 32'h0);
        check_eq("counts pre-fill", out_count, cnt(32'h01030A01));
        for (int s = 0; s < 4; s++) begin
            in_sel   = 2'(s);
            in_data  = 8'(8'h40 + s);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        check_eq("all full", 32'(out_valid), 32'hF);
        check_eq("fill data", out_data, 32'h43424140);
        rst       = 1'b1;
        out_ready = 4'hF;
        in_sel    = 2'd1;
        in_data   = 8'hEE;
        in_valid  = 1'b1;
        #1;
        check_eq("rst in_ready", 32'(in_ready), 32'h1);
        step();
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 4'h0;
        check_eq("midrst out_valid", 32'(out_valid), 32'h0);
        check_eq("midrst out_count", out_count, 32'h0);
        check_eq("midrst out_data", out_data, 32'h0);
        step();
        check_eq("no stale word", 32'(out_valid), 32'h0);
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1;
            check_eq($sformatf("post-rst in_ready sel%0d", s), 32'(in_ready), 32'h1);
        end

        // Counter wrap: 256 transfers on channel 0 from a cleared count
        in_sel    = 2'd0;
        out_ready = 4'b0001;
        for (int i = 0; i < 256; i++) begin
            in_data  = 8'(i);
            in_valid = 1'b1;
            step();
            check_eq($sformatf("wrap data %0d", i), 32'(out_data[7:0]), 32'(i));
            check_eq($sformatf("wrap count %0d", i), out_count, cnt(32'(i)));
        end
        in_valid = 1'b0;
        step();
        check_eq("wrap count final", out_count, 32'h0);
        check_eq("wrap empty", 32'(out_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
